// File: rtl/pinwheel_console.sv
// pinwheel_console
//   Data-bus responder for one console region of the pinwheel address map.
//   Single-cycle bus requests are decoded by the top address nibble. Read
//   data is registered and returned one cycle later. Bytes written to
//   TXDATA are queued in a byte FIFO and drained to a host sink over a
//   valid/ready stream.
//
// Ports
//   clock      global clock, all state on rising edge
//   reset_n    asynchronous active-low reset
//   bus_addr   byte address; [31:28] selects this console, [3:2] the register
//   bus_rdata  registered read data, valid the cycle after bus_rden
//   bus_wdata  write data
//   bus_wmask  byte-lane write mask
//   bus_rden   read strobe, single cycle
//   bus_wren   write strobe, single cycle
//   tx_data    FIFO head byte
//   tx_valid   head byte available to sink
//   tx_ready   sink accepts head byte this cycle
//
// Register map (offset = bus_addr[3:2] * 4)
//   0x0 TXDATA  W   push wdata[7:0] when wmask[0]; reads 0
//   0x4 STATUS  R   {drops[15:0], count[7:0], 6'b0, full, empty}
//   0x8 CTRL    RW  bit0 enable (reset 1), bit1 flush (self-clearing, reads 0)
//   0xC DROPS   RW  saturating count of rejected pushes; any write clears
module pinwheel_console #(
  parameter logic [3:0] BUS_TAG = 4'h4,
  parameter int         DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] bus_addr,
  input  logic        bus_rden,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wren,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DROPS  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drops;
  logic          enable;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          push_rej;
  logic          ctrl_wr;
  logic          flush;
  logic          drops_clr;
  logic [8:0]    count_w;
  logic [31:0]   reg_val;

  // Address bits outside the tag and register index are aliases.
  logic unused_bits;
  assign unused_bits = ^{bus_addr[27:4], bus_addr[1:0], bus_wdata[31:8], bus_wmask[3:1]};

  assign sel     = (bus_addr[31:28] == BUS_TAG);
  assign reg_idx = bus_addr[3:2];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign tx_valid = enable & ~empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;

  assign push_req  = bus_wren & sel & (reg_idx == REG_TXDATA) & bus_wmask[0];
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok   = push_req & (~full | pop);
  assign push_rej  = push_req & ~push_ok;
  assign ctrl_wr   = bus_wren & sel & (reg_idx == REG_CTRL) & bus_wmask[0];
  assign flush     = ctrl_wr & bus_wdata[1];
  assign drops_clr = bus_wren & sel & (reg_idx == REG_DROPS);

  assign count_w = 9'(count);

  always_comb begin
    reg_val = '0;
    case (reg_idx)
      REG_STATUS: reg_val = {drops, count_w[7:0], 6'b0, full, empty};
      REG_CTRL:   reg_val = {31'b0, enable};
      REG_DROPS:  reg_val = {16'b0, drops};
      default:    reg_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drops     <= '0;
      enable    <= 1'b1;
      bus_rdata <= '0;
    end else begin
      bus_rdata <= (bus_rden & sel) ? reg_val : '0;

      if (ctrl_wr)
        enable <= bus_wdata[0];

      // Flush overrides any same-cycle push or pop.
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)
          count <= count + CW'(1);
        else if (pop && !push_ok)
          count <= count - CW'(1);
      end

      if (drops_clr)
        drops <= '0;
      else if (push_rej && !flush && drops != 16'hFFFF)
        drops <= drops + 16'd1;
    end
  end

  // Storage is not reset; tx_data is only meaningful while tx_valid is high.
  always_ff @(posedge clock) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= bus_wdata[7:0];
  end

endmodule

// File: tb/tb_pinwheel_console.sv
module tb_pinwheel_console;

  logic        clock;
  logic        reset_n;
  logic [31:0] bus_addr;
  logic        bus_rden;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_wren;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  localparam logic [31:0] A_TX     = 32'h4000_0000;
  localparam logic [31:0] A_STATUS = 32'h4000_0004;
  localparam logic [31:0] A_CTRL   = 32'h4000_0008;
  localparam logic [31:0] A_DROPS  = 32'h4000_000C;

  pinwheel_console #(.BUS_TAG(4'h4), .DEPTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus_addr  (bus_addr),
    .bus_rden  (bus_rden),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_wren  (bus_wren),
    .bus_rdata (bus_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive on the falling edge, return just after the rising
  // edge so bus_rdata holds the result of a read.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    @(negedge clock);
    bus_rden  = rd;
    bus_wren  = wr;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wmask = mask;
    @(posedge clock);
    #1;
    bus_rden  = 1'b0;
    bus_wren  = 1'b0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] wdata);
    bus_cycle(1'b0, 1'b1, addr, wdata, 4'hF);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    bus_cycle(1'b1, 1'b0, addr, 32'h0, 4'h0);
    check(tag, bus_rdata, expected);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus_addr  = '0;
    bus_rden  = 1'b0;
    bus_wdata = '0;
    bus_wmask = '0;
    bus_wren  = 1'b0;
    tx_ready  = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_rdata", bus_rdata, 32'h0);
    reset_n = 1'b1;

    // 1: streaming with sink ready
    read_check("reset_status", A_STATUS, 32'h0000_0001);
    read_check("reset_ctrl", A_CTRL, 32'h0000_0001);
    tx_ready = 1'b1;
    write(A_TX, 32'h41);
    check("t1_v0", {31'b0, tx_valid}, 32'h1);
    check("t1_d0", {24'b0, tx_data}, 32'h41);
    write(A_TX, 32'h42);
    check("t1_d1", {24'b0, tx_data}, 32'h42);
    write(A_TX, 32'h43);
    check("t1_d2", {24'b0, tx_data}, 32'h43);
    @(posedge clock);
    #1;
    check("t1_empty_valid", {31'b0, tx_valid}, 32'h0);
    read_check("t1_status", A_STATUS, 32'h0000_0001);

    // 2: overflow with sink stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 19; i++) write(A_TX, 32'h10 + i);
    read_check("t2_status", A_STATUS, 32'h0003_1002);
    // read and write DROPS in one cycle: read returns the pre-clear value
    bus_cycle(1'b1, 1'b1, A_DROPS, 32'h0, 4'h0);
    check("t2_drops_rw", bus_rdata, 32'h0000_0003);
    read_check("t2_drops_clr", A_DROPS, 32'h0);
    @(negedge clock);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", {23'b0, tx_valid, tx_data}, 32'h100 + 32'h10 + i);
      @(negedge clock);
    end
    tx_ready = 1'b0;
    check("t2_drained", {31'b0, tx_valid}, 32'h0);

    // 3: push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 16; i++) write(A_TX, 32'h60 + i);
    @(negedge clock);
    tx_ready  = 1'b1;
    bus_wren  = 1'b1;
    bus_addr  = A_TX;
    bus_wdata = 32'h70;
    bus_wmask = 4'h1;
    @(posedge clock);
    #1;
    bus_wren = 1'b0;
    tx_ready = 1'b0;
    check("t3_head", {24'b0, tx_data}, 32'h61);
    read_check("t3_status", A_STATUS, 32'h0000_1002);
    @(negedge clock);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_drain", {24'b0, tx_data}, (i < 15) ? 32'h61 + i : 32'h70);
      @(negedge clock);
    end
    tx_ready = 1'b0;
    check("t3_drained", {31'b0, tx_valid}, 32'h0);

    // 4: read latency, aliases and foreign tags
    @(negedge clock);
    bus_rden = 1'b1;
    bus_addr = 32'h4ABC_DEF7;
    #1;
    check("t4_rd_n", bus_rdata, 32'h0);
    @(posedge clock);
    #1;
    bus_rden = 1'b0;
    check("t4_rd_n1", bus_rdata, 32'h0000_0001);
    @(posedge clock);
    #1;
    check("t4_rd_n2", bus_rdata, 32'h0);
    read_check("t4_foreign_rd", 32'h8000_0004, 32'h0);
    write(32'h8000_0000, 32'h55);
    bus_cycle(1'b0, 1'b1, A_TX, 32'h56, 4'b1110);
    check("t4_nopush_valid", {31'b0, tx_valid}, 32'h0);
    read_check("t4_status", A_STATUS, 32'h0000_0001);

    // 5: disable, flush, re-enable
    write(A_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) write(A_TX, 32'hA0 + i);
    @(negedge clock);
    tx_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("t5_disabled_valid", {31'b0, tx_valid}, 32'h0);
    read_check("t5_status", A_STATUS, 32'h0000_0400);
    write(A_CTRL, 32'h2);
    read_check("t5_flushed", A_STATUS, 32'h0000_0001);
    read_check("t5_ctrl0", A_CTRL, 32'h0);
    write(A_CTRL, 32'h1);
    check("t5_enabled_valid", {31'b0, tx_valid}, 32'h0);
    read_check("t5_ctrl1", A_CTRL, 32'h1);
    tx_ready = 1'b0;

    // 6: asynchronous reset with bytes queued
    write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) write(A_TX, 32'hC0 + i);
    write(A_CTRL, 32'h1);
    check("t6_valid_before", {31'b0, tx_valid}, 32'h1);
    read_check("t6_status_before", A_STATUS, 32'h0000_0500);
    @(negedge clock);
    tx_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid_async", {31'b0, tx_valid}, 32'h0);
    check("t6_rdata_async", bus_rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    read_check("t6_status_after", A_STATUS, 32'h0000_0001);
    read_check("t6_ctrl_after", A_CTRL, 32'h0000_0001);
    tx_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
